// File: rtl/loader_pkg.sv
// Shared constants and state types for the UART instruction-memory loader.
package loader_pkg;

  // Same constant the CPU halt check compares against.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    TOP_LOAD,
    TOP_DONE
  } top_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, bit timer and RX state machine.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            wait_hi_q, wait_hi_d;

  // Two-flop synchroniser, idle-high after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Next-state, bit timing and sampling; after a bad stop bit the line must go high before a new start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    wait_hi_d = wait_hi_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (wait_hi_q) begin
          if (rx_sync_q) wait_hi_d = 1'b0;
        end else if (!rx_sync_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            wait_hi_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_hi_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      wait_hi_q <= wait_hi_d;
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign stop_err   = err_q;

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: assembles big-endian words and writes them to instruction memory.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  frame_err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  top_state_e            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           acc_q, acc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       stop_err;
  logic       rx_gated;

  // Once loading is finished the line is forced idle so the receiver parks.
  assign rx_gated = rx | done_q;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_gated),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .stop_err   (stop_err)
  );

  // Word assembly, write strobe and LOAD/DONE transitions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    cnt_d   = cnt_q;
    if (state_q == TOP_LOAD) begin
      if (stop_err) begin
        ferr_d = 1'b1;
        idx_d  = '0;
      end else if (byte_valid) begin
        acc_d = {acc_q[23:0], byte_data};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = {acc_q[23:0], byte_data};
        end
      end
      if (we_q) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (waddr_q != LAST_ADDR) waddr_d = waddr_q + ADDR_WIDTH'(1);
        if (wdata_q == HALT_WORD || waddr_q == LAST_ADDR) begin
          state_d = TOP_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TOP_LOAD;
      idx_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign frame_err  = ferr_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised bench for imem_uart_loader: a full-size and a 4-word instance against a byte-level model.
module tb_imem_uart_loader;

  localparam int unsigned CLK_HZ = 160;
  localparam int unsigned BAUD   = 10;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst_a, rst_b, rx_a, rx_b;

  logic        we_a, hold_a, done_a, ferr_a;
  logic [7:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;
  logic        we_b, hold_b, done_b, ferr_b;
  logic [1:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst_a), .rx(rx_a), .imem_we(we_a), .imem_waddr(waddr_a),
    .imem_wdata(wdata_a), .cpu_hold(hold_a), .done(done_a), .frame_err(ferr_a),
    .word_cnt(cnt_a)
  );

  imem_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst_b), .rx(rx_b), .imem_we(we_b), .imem_waddr(waddr_b),
    .imem_wdata(wdata_b), .cpu_hold(hold_b), .done(done_b), .frame_err(ferr_b),
    .word_cnt(cnt_b)
  );

  // Uniform views of both instances.
  logic        we_s[2], hold_s[2], done_s[2], ferr_s[2];
  logic [7:0]  addr_s[2];
  logic [31:0] data_s[2];
  logic [8:0]  cnt_s[2];
  assign we_s[0] = we_a;     assign we_s[1] = we_b;
  assign hold_s[0] = hold_a; assign hold_s[1] = hold_b;
  assign done_s[0] = done_a; assign done_s[1] = done_b;
  assign ferr_s[0] = ferr_a; assign ferr_s[1] = ferr_b;
  assign addr_s[0] = waddr_a; assign addr_s[1] = 8'(waddr_b);
  assign data_s[0] = wdata_a; assign data_s[1] = wdata_b;
  assign cnt_s[0] = cnt_a;    assign cnt_s[1] = 9'(cnt_b);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: bytes in, expected writes out.
  int          depth[2];
  int          m_idx[2], m_addr[2], m_cnt[2];
  logic [31:0] m_acc[2];
  bit          m_done[2], m_ferr[2];
  int          e_addr[2][0:63];
  logic [31:0] e_data[2][0:63];
  bit          e_last[2][0:63];
  int          exp_n[2], got_n[2];
  bit          pend_done[2], prev_we[2];

  task automatic model_reset(input int d);
    m_idx[d] = 0; m_acc[d] = 0; m_addr[d] = 0; m_cnt[d] = 0;
    m_done[d] = 0; m_ferr[d] = 0;
    exp_n[d] = 0; got_n[d] = 0; pend_done[d] = 0;
  endtask

  task automatic model_byte(input int d, input logic [7:0] b, input logic good);
    bit last;
    if (m_done[d]) return;
    if (!good) begin
      m_ferr[d] = 1;
      m_idx[d]  = 0;
      return;
    end
    m_acc[d] = (m_acc[d] << 8) | 32'(b);
    m_idx[d]++;
    if (m_idx[d] == 4) begin
      last = (m_acc[d] == 32'hFFFF_FFFF) || (m_addr[d] == depth[d] - 1);
      e_addr[d][exp_n[d]] = m_addr[d];
      e_data[d][exp_n[d]] = m_acc[d];
      e_last[d][exp_n[d]] = last;
      exp_n[d]++;
      m_cnt[d]++;
      m_addr[d]++;
      m_idx[d] = 0;
      if (last) m_done[d] = 1;
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pend_done[d]) begin
        check($sformatf("done_after_last%0d", d), {62'd0, done_s[d], hold_s[d]}, 64'd2);
        pend_done[d] = 0;
      end
      if (we_s[d]) begin
        check($sformatf("we_one_cycle%0d", d), 64'(prev_we[d]), 64'd0);
        if (got_n[d] < exp_n[d]) begin
          check($sformatf("waddr%0d", d), 64'(addr_s[d]), 64'(e_addr[d][got_n[d]]));
          check($sformatf("wdata%0d", d), 64'(data_s[d]), 64'(e_data[d][got_n[d]]));
          pend_done[d] = e_last[d][got_n[d]];
          got_n[d]++;
        end else begin
          check($sformatf("spurious_we%0d", d), 64'd1, 64'd0);
        end
      end
      prev_we[d] = we_s[d];
    end
  end

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    model_byte(d, b, stop);
    for (int i = 0; i < 10; i++) begin
      set_rx(d, frame[i]);
      repeat (DIV) @(posedge clk);
    end
    set_rx(d, 1'b1);
    repeat (DIV + $urandom_range(0, 24)) @(posedge clk);
  endtask

  task automatic send_word(input int d, input logic [31:0] w);
    send_byte(d, w[31:24], 1'b1);
    send_byte(d, w[23:16], 1'b1);
    send_byte(d, w[15:8],  1'b1);
    send_byte(d, w[7:0],   1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic check_reset(input int d);
    check($sformatf("rst_we%0d", d),    64'(we_s[d]),   64'd0);
    check($sformatf("rst_waddr%0d", d), 64'(addr_s[d]), 64'd0);
    check($sformatf("rst_wdata%0d", d), 64'(data_s[d]), 64'd0);
    check($sformatf("rst_cnt%0d", d),   64'(cnt_s[d]),  64'd0);
    check($sformatf("rst_flags%0d", d),
          {61'd0, hold_s[d], done_s[d], ferr_s[d]}, 64'd4);
  endtask

  task automatic check_state(input int d, input string tag);
    check({tag, "_writes"}, 64'(got_n[d]), 64'(exp_n[d]));
    check({tag, "_cnt"},    64'(cnt_s[d]), 64'(m_cnt[d]));
    check({tag, "_done"},   64'(done_s[d]), 64'(m_done[d]));
    check({tag, "_hold"},   64'(hold_s[d]), 64'(!m_done[d]));
    check({tag, "_ferr"},   64'(ferr_s[d]), 64'(m_ferr[d]));
  endtask

  initial begin
    depth[0] = 256;
    depth[1] = 4;
    prev_we[0] = 0; prev_we[1] = 0;
    model_reset(0);
    model_reset(1);
    rx_a = 1'b1; rx_b = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (20) @(posedge clk);

    // First word.
    send_word(0, 32'h2008_0005);
    check_state(0, "word1");

    // Short low glitch on an idle line.
    @(posedge clk);
    rx_a = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    rx_a = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    check_state(0, "glitch");

    // Bad stop bit on the second byte of a word, then a clean word.
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b0);
    check_state(0, "badstop");
    send_word(0, 32'hAABB_CCDD);
    check_state(0, "after_err");

    // Random words.
    for (int i = 0; i < 3; i++) send_word(0, rand_word());
    check_state(0, "random");

    // Reset between bytes 2 and 3 of a word.
    send_byte(0, 8'($urandom), 1'b1);
    send_byte(0, 8'($urandom), 1'b1);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check_reset(0);
    model_reset(0);
    repeat (5) @(negedge clk);
    rst_a = 1'b1;
    send_word(0, rand_word());
    check_state(0, "post_rst");

    // Halt word ends the load; later traffic is ignored.
    send_word(0, 32'h2008_0005);
    send_word(0, 32'h0085_1020);
    send_word(0, 32'hFFFF_FFFF);
    check_state(0, "halt");
    send_word(0, rand_word());
    check_state(0, "after_halt");

    // Small memory fills up after four words.
    for (int i = 0; i < 4; i++) send_word(1, rand_word());
    check_state(1, "full");
    send_word(1, rand_word());
    check_state(1, "after_full");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Serial boot loader: the write side of the instruction memory that the CPU fetch path reads.
- Receives a program over a UART line (8N1), assembles bytes into 32-bit big-endian words, and writes them to consecutive instruction-memory word addresses.
- Holds the CPU in reset while loading. Releases the CPU after the halt word 32'hFFFFFFFF is written, or when memory is full.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate. DIV = CLK_HZ/BAUD (integer division) clocks per bit.
- ADDR_WIDTH, 8, instruction-memory word-address width (depth = 2^ADDR_WIDTH words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_waddr  out  ADDR_WIDTH  word address of the current write.
- imem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  high while loading; drives the CPU reset.
- done  out  1  load complete; sticky until rst.
- frame_err  out  1  sticky; set on any bad stop bit.
- word_cnt  out  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Reset values (rst low, asynchronous):
  - imem_we=0, imem_waddr=0, imem_wdata=0, word_cnt=0.
  - cpu_hold=1, done=0, frame_err=0.
  - Both FSMs go to initial state; byte index = 0.
- rx is synchronised through 2 flops, initialised high. All decisions use the synchronised value.
- RX FSM states IDLE, START, DATA, STOP:
  - IDLE: synchronised rx = 0 -> START, bit timer cleared.
  - START: after DIV/2 clocks, sample rx. If 0 -> DATA; if 1 -> IDLE (glitch, no byte).
  - DATA: sample every DIV clocks, 8 bits, LSB first, then -> STOP.
  - STOP: after DIV clocks, sample rx.
    - rx = 1: byte_valid pulses for one cycle -> IDLE.
    - rx = 0: frame_err <= 1, byte dropped, partial word discarded (byte index <= 0) -> IDLE (waits for rx high before a new start).
- Word assembly:
  - Bytes arrive MSB first: byte 0 -> wdata[31:24] ... byte 3 -> wdata[7:0].
  - 2-bit byte index wraps 3 -> 0 on the 4th byte.
- Write:
  - The cycle after byte_valid for byte 3: imem_we=1 for exactly one cycle, with imem_waddr = current address and imem_wdata = assembled word.
  - Next cycle: address +1, word_cnt +1.
  - waddr/wdata hold their values after the strobe.
- Top FSM states LOAD, DONE:
  - LOAD -> DONE in the cycle after the strobe if the written word == HALT_WORD (the halt word itself is written) or word_cnt reaches 2^ADDR_WIDTH.
  - In DONE: cpu_hold=0, done=1, imem_we never asserts, rx is ignored (RX FSM parked in IDLE).
- Address never wraps: a write at the last address always ends the load.
- frame_err does not stop loading; subsequent good bytes continue at the current address.
- Reset mid-byte or mid-word discards all partial state. The next load restarts at address 0 with cpu_hold=1.

Decomposition:
- Shared package loader_pkg:
  - HALT_WORD = 32'hFFFFFFFF, the same constant the CPU halt check uses.
  - RX state enum.
  - Top state enum.
- Sub-module uart_rx:
  - Parameters CLK_HZ, BAUD.
  - Ports: clk, rst, rx, byte_data[7:0], byte_valid, stop_err.
  - Contains the synchroniser, bit timer and RX FSM.
- The top assembles words, generates writes and runs the LOAD/DONE FSM.

Test Plan:
- Bytes 20 08 00 05 -> single imem_we with waddr=0, wdata=32'h20080005; word_cnt=1; cpu_hold stays 1.
- Words 20080005, 00851020, then FF FF FF FF -> writes at 0, 1, 2 (third wdata=FFFFFFFF); done=1 and cpu_hold=0 the cycle after the third strobe; further bytes produce no imem_we.
- Byte 2 of a word sent with stop bit 0 -> frame_err=1, no strobe; next 4 good bytes AABBCCDD -> write at waddr=0, wdata=AABBCCDD.
- rx pulled low for DIV/4 clocks then high -> no byte_valid, no strobe, frame_err stays 0.
- ADDR_WIDTH=2, four non-halt words -> strobes at 0..3, done=1 after the 4th; a 5th word is ignored.
- rst asserted between bytes 2 and 3 -> all outputs take reset values immediately; after release, a full word is written at waddr=0.
